sr_flag_arbiter: RTL and testbench
==================================

// Module: sr_flag_arbiter
// PURPOSE
//  Shares a bank of NFLAG SR flip-flops (status flags) between NREQ requesters.
//  Each requester posts a set or clear command for one flag index. A round-robin arbiter
//  grants one command at a time and drives a single-cycle S or R pulse into the bank.
//  It then checks the flag's Q and reports completion or mismatch.
//  Sits between request agents and the sr_flipflop bank. It is the only driver of S/R.
// PARAMETERS
//  NREQ   4                number of requesters (>=2)
//  NFLAG  8                number of SR flip-flops in the bank (>=2)
//  IDXW   $clog2(NFLAG)    flag index width (derived, do not override)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NREQ        requester i has a pending command
//  req_op     in   NREQ        per requester: 1 = set flag, 0 = clear flag
//  req_idx    in   NREQ*IDXW   per requester flag index, requester i at [i*IDXW +: IDXW]
//  req_ready  out  NREQ        one-hot grant pulse; command accepted this cycle
//  S          out  NFLAG       set pulses to bank
//  R          out  NFLAG       reset pulses to bank
//  Q          in   NFLAG       flag outputs from bank
//  busy       out  1           state != IDLE
//  done       out  1           1-cycle completion pulse
//  done_id    out  $clog2(NREQ) requester whose command completed (valid with done)
//  done_ok    out  1           1 = Q matched the commanded value (valid with done)
//  err_sticky out  1           set on any done with done_ok=0; cleared only by rst
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, S=R=0, req_ready=0, done=0, done_id=0,
//   done_ok=0, err_sticky=0, rr pointer=0. Reset mid-command abandons it with no done pulse.
//   S/R are 0 from the next edge.
//  FSM: IDLE -> DRIVE -> CHECK -> IDLE. All outputs are registered.
//   IDLE: if any req_valid, grant the first valid requester at or after rr pointer (wrapping).
//     req_ready[g]=1 for exactly that cycle.
//     Latch op/idx/id, then rr pointer <= (g+1) mod NREQ, and go to DRIVE.
//     With no valid request, stay in IDLE.
//   DRIVE: exactly one bit is high. S[idx]=1 if op=1, else R[idx]=1. All other S/R bits are 0.
//     Go to CHECK.
//   CHECK: S=R=0. Compare Q[idx] with op, then done=1, done_id=id, done_ok=(Q[idx]==op).
//     If done_ok=0, err_sticky<=1. Go to IDLE.
//  Latency: grant at cycle T, S/R pulse at T+1, done at T+2.
//   The next grant is possible at T+3, so peak throughput is 1 command per 3 cycles.
//  Handshake: the requester holds valid/op/idx stable until req_ready. It may drop valid
//   in the cycle after req_ready. Changing op/idx while waiting is allowed; the sampled
//   value is the one at the grant edge.
//  Invariant: (S & R)==0 and popcount(S|R)<=1 in every cycle. The block never produces
//   the S=R=1 case.
//  Simultaneous: several valid requesters resolve by round-robin only. Two requesters
//   targeting the same idx with opposite ops are serialized; the later grant wins the
//   final Q value.
//  Redundant command (Q already equals op): the pulse is still driven, and the command
//   completes with done_ok=1.
//  Out-of-range idx (idx>=NFLAG, NFLAG not a power of 2): no S/R bit is driven.
//   The command completes with done_ok=0.
// TESTING
//  1 rst=1 for 2 cycles with req_valid=4'hF -> no req_ready; S=R=0, busy=0, err_sticky=0.
//  2 Req0 set idx3 only -> req_ready=0001 at T, S=8'h08 at T+1, done at T+2.
//    Expect done_id=0, done_ok=1, Q[3]=1.
//  3 All 4 valid, each set a distinct idx, held -> grants 0,1,2,3, then 0 again, each
//    3 cycles apart. Check (S&R)==0 every cycle.
//  4 Req1 set idx5, req2 clear idx5, both valid -> req1 granted first, then req2.
//    Final Q[5]=0 with two done_ok=1.
//  5 Bench model forces Q[2] stuck at 0 and sends set idx2 -> done_ok=0, err_sticky=1.
//    err_sticky stays 1 until rst.
//  6 Assert rst during DRIVE -> no done pulse; S=R=0 at next edge; pointer=0.
//    A new request is granted normally.

Source files
------------

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing a bank of SR status flags between several requesters.
// Each granted command produces one S or R pulse, then the flag is read back and reported.
//
// state | meaning
// IDLE  | waiting for a request; grants the first valid requester at/after rr_ptr
// DRIVE | command latched, registering the single S or R pulse
// CHECK | pulse on the bank, sampling Q[idx] and reporting done/done_ok
module sr_flag_arbiter #(
   parameter  int NREQ  = 4,
   parameter  int NFLAG = 8,
   localparam int IDXW  = $clog2(NFLAG),
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NREQ-1:0]      req_ready,
   output logic [NFLAG-1:0]     S,
   output logic [NFLAG-1:0]     R,
   input  logic [NFLAG-1:0]     Q,
   output logic                 busy,
   output logic                 done,
   output logic [IDW-1:0]       done_id,
   output logic                 done_ok,
   output logic                 err_sticky
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2
   } state_t;

   state_t            state, state_nx;
   logic [IDW-1:0]    rr_ptr, rr_ptr_nx;
   logic [IDW-1:0]    id_q, id_nx;
   logic              op_q, op_nx;
   logic [IDXW-1:0]   idx_q, idx_nx;

   logic [NREQ-1:0]   ready_nx;
   logic [NFLAG-1:0]  s_nx, r_nx;
   logic              done_nx, done_ok_nx, err_nx;
   logic [IDW-1:0]    done_id_nx;

   logic              gnt_any;
   logic [IDW-1:0]    gnt_id;
   logic [NFLAG-1:0]  flag_sel;
   logic              idx_in_range;
   logic              q_bit;

   // Lowest offset from rr_ptr wins; scanning high-to-low lets the last hit be the winner.
   always_comb begin
      int cand;
      gnt_any = 1'b0;
      gnt_id  = '0;
      cand    = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NREQ) cand = cand - NREQ;
         if (req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_id  = IDW'(cand);
         end
      end
   end

   // An index beyond the bank decodes to no flag at all, so nothing is pulsed.
   always_comb begin
      flag_sel = '0;
      q_bit    = 1'b0;
      for (int f = 0; f < NFLAG; f++) begin
         if (int'(idx_q) == f) begin
            flag_sel[f] = 1'b1;
            q_bit       = Q[f];
         end
      end
      idx_in_range = |flag_sel;
   end

   always_comb begin
      int nxt;
      state_nx   = state;
      rr_ptr_nx  = rr_ptr;
      id_nx      = id_q;
      op_nx      = op_q;
      idx_nx     = idx_q;
      ready_nx   = '0;
      s_nx       = '0;
      r_nx       = '0;
      done_nx    = 1'b0;
      done_id_nx = done_id;
      done_ok_nx = done_ok;
      err_nx     = err_sticky;
      nxt        = 0;

      unique case (state)
         IDLE: begin
            if (gnt_any) begin
               ready_nx[gnt_id] = 1'b1;
               id_nx            = gnt_id;
               op_nx            = req_op[gnt_id];
               idx_nx           = req_idx[int'(gnt_id)*IDXW +: IDXW];
               nxt              = int'(gnt_id) + 1;
               if (nxt >= NREQ) nxt = 0;
               rr_ptr_nx        = IDW'(nxt);
               state_nx         = DRIVE;
            end
         end
         DRIVE: begin
            if (op_q) s_nx = flag_sel;
            else      r_nx = flag_sel;
            state_nx = CHECK;
         end
         CHECK: begin
            done_nx    = 1'b1;
            done_id_nx = id_q;
            done_ok_nx = idx_in_range && (q_bit == op_q);
            if (!(idx_in_range && (q_bit == op_q))) err_nx = 1'b1;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         id_q       <= '0;
         op_q       <= 1'b0;
         idx_q      <= '0;
         req_ready  <= '0;
         S          <= '0;
         R          <= '0;
         done       <= 1'b0;
         done_id    <= '0;
         done_ok    <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         state      <= state_nx;
         rr_ptr     <= rr_ptr_nx;
         id_q       <= id_nx;
         op_q       <= op_nx;
         idx_q      <= idx_nx;
         req_ready  <= ready_nx;
         S          <= s_nx;
         R          <= r_nx;
         done       <= done_nx;
         done_id    <= done_id_nx;
         done_ok    <= done_ok_nx;
         err_sticky <= err_nx;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a transaction-level reference model predicts grants,
// pulses and completions; a monitor compares them against the DUT and a latch-style flag bank.
module tb_sr_flag_arbiter;
   localparam int NREQ  = 4;
   localparam int NFLAG = 8;
   localparam int IDXW  = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NREQ-1:0]      req_valid = '1;
   logic [NREQ-1:0]      req_op = '0;
   logic [NREQ*IDXW-1:0] req_idx = '0;
   logic [NREQ-1:0]      req_ready;
   logic [NFLAG-1:0]     S, R;
   logic [NFLAG-1:0]     q_bank = '0;
   logic [NFLAG-1:0]     stuck0 = '0;
   logic                 busy, done, done_ok, err_sticky;
   logic [1:0]           done_id;

   int checks = 0;
   int errors = 0;

   sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx),
      .req_ready(req_ready), .S(S), .R(R), .Q(q_bank),
      .busy(busy), .done(done), .done_id(done_id), .done_ok(done_ok),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   // Flag bank: level-sensitive SR cells, with optional stuck-at-0 bits.
   always @(S or R or stuck0) begin
      for (int i = 0; i < NFLAG; i++) begin
         if (S[i])      q_bank[i] = 1'b1;
         else if (R[i]) q_bank[i] = 1'b0;
         if (stuck0[i]) q_bank[i] = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int     id;
      bit     op;
      int     idx;
      longint gcyc;
   } cmd_t;

   cmd_t       q_exp[$];
   longint     cyc = 0;
   int         mptr = 0;
   int         mwait = 0;
   bit         msticky = 0;
   bit         chk_en = 0;
   bit [NFLAG-1:0] mflag = '0;

   // A command occupies the arbiter for three cycles; grants go round-robin from mptr.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         q_exp.delete();
         mptr    = 0;
         mwait   = 0;
         msticky = 0;
         chk_en  = 1;
      end else if (mwait > 0) begin
         mwait--;
      end else if (req_valid != '0) begin
         for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (mptr + k) % NREQ;
            if (req_valid[c]) begin
               cmd_t e;
               e.id   = c;
               e.op   = req_op[c];
               e.idx  = int'(req_idx[c*IDXW +: IDXW]);
               e.gcyc = cyc;
               q_exp.push_back(e);
               mptr  = (c + 1) % NREQ;
               mwait = 2;
               break;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         logic [NREQ-1:0]  exp_rdy;
         logic [NFLAG-1:0] exp_s, exp_r;
         logic             exp_busy;
         exp_rdy  = '0;
         exp_s    = '0;
         exp_r    = '0;
         exp_busy = 1'b0;
         if (q_exp.size() != 0) begin
            cmd_t e;
            e = q_exp[0];
            if (cyc == e.gcyc) begin
               exp_rdy[e.id] = 1'b1;
               exp_busy      = 1'b1;
            end
            if (cyc == e.gcyc + 1) begin
               exp_busy = 1'b1;
               if (e.op) exp_s[e.idx] = 1'b1;
               else      exp_r[e.idx] = 1'b1;
               mflag[e.idx] = e.op && !stuck0[e.idx];
            end
         end
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("S", 32'(S), 32'(exp_s));
         chk("R", 32'(R), 32'(exp_r));
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("s_and_r", 32'(S & R), 32'd0);
         chk("pulse_count", 32'($countones(S | R) <= 1), 32'd1);

         if (done === 1'b1) begin
            if (q_exp.size() == 0) begin
               chk("done_unexpected", 32'(done), 32'd0);
            end else begin
               cmd_t e;
               bit   ok;
               e  = q_exp.pop_front();
               ok = (mflag[e.idx] == e.op);
               if (!ok) msticky = 1;
               chk("done_latency", 32'(cyc - e.gcyc), 32'd2);
               chk("done_id", 32'(done_id), 32'(e.id));
               chk("done_ok", 32'(done_ok), 32'(ok));
            end
         end else if (q_exp.size() != 0 && cyc >= q_exp[0].gcyc + 2) begin
            chk("done_missing", 32'(done), 32'd1);
            void'(q_exp.pop_front());
         end
         chk("err_sticky", 32'(err_sticky), 32'(msticky));
      end
   end

   // ---------------- requester driver ----------------
   bit hold = 0;
   bit rand_en = 0;

   always @(negedge clk) begin
      for (int i = 0; i < NREQ; i++) begin
         if (req_ready[i] === 1'b1 && !hold) req_valid[i] = 1'b0;
         if (rand_en) begin
            if (!req_valid[i]) begin
               if ($urandom_range(2) == 0) begin
                  req_valid[i]            = 1'b1;
                  req_op[i]               = 1'($urandom_range(1));
                  req_idx[i*IDXW +: IDXW] = 3'($urandom_range(7));
               end
            end else if (req_ready[i] !== 1'b1 && $urandom_range(7) == 0) begin
               req_op[i]               = 1'($urandom_range(1));
               req_idx[i*IDXW +: IDXW] = 3'($urandom_range(7));
            end
         end
      end
   end

   task automatic post(input int i, input bit op, input int idx);
      req_valid[i]            = 1'b1;
      req_op[i]               = op;
      req_idx[i*IDXW +: IDXW] = 3'(idx);
   endtask

   task automatic wait_quiet();
      int n;
      n = 0;
      while ((req_valid != '0 || q_exp.size() != 0) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("quiet_timeout", 32'(n), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset held with every requester asking
      repeat (2) @(posedge clk);
      #1;
      chk("rst_no_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst       = 1'b0;
      req_valid = '0;

      // single set of flag 3
      @(posedge clk); #1;
      post(0, 1'b1, 3);
      wait_quiet();
      chk("q3_set", 32'(q_bank[3]), 32'd1);

      // four held requesters cycle through the round-robin
      @(posedge clk); #1;
      hold = 1;
      post(0, 1'b1, 0);
      post(1, 1'b1, 1);
      post(2, 1'b1, 2);
      post(3, 1'b1, 4);
      repeat (16) @(posedge clk);
      #1;
      req_valid = '0;
      hold = 0;
      wait_quiet();

      // opposite commands on flag 5, later grant wins
      do_reset();
      post(1, 1'b1, 5);
      post(2, 1'b0, 5);
      wait_quiet();
      chk("q5_final", 32'(q_bank[5]), 32'd0);

      // stuck flag 2 produces a mismatch and a sticky error
      stuck0 = 8'h04;
      @(posedge clk); #1;
      post(0, 1'b1, 2);
      wait_quiet();
      chk("sticky_set", 32'(err_sticky), 32'd1);
      repeat (10) @(negedge clk);
      chk("sticky_hold", 32'(err_sticky), 32'd1);
      stuck0 = '0;
      do_reset();
      @(negedge clk);
      chk("sticky_cleared", 32'(err_sticky), 32'd0);

      // reset while the command is in DRIVE
      @(posedge clk); #1;
      post(3, 1'b1, 6);
      @(posedge clk); #1;
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abandoned_q6", 32'(q_bank[6]), 32'd0);
      @(posedge clk); #1;
      post(2, 1'b0, 1);
      post(0, 1'b1, 7);
      @(posedge clk);
      @(negedge clk);
      chk("ptr_after_rst", 32'(req_ready), 32'h1);
      wait_quiet();

      // randomized traffic with one stuck flag
      do_reset();
      stuck0  = 8'h40;
      rand_en = 1;
      repeat (600) @(negedge clk);
      rand_en = 0;
      wait_quiet();
      stuck0 = '0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
